// File: rtl/font_glyph_writer_pkg.sv
// Shared constants, FSM state type and glyph address helper for the font writer.
package font_pkg;

    localparam int FONT_ROWS  = 12;
    localparam int FONT_CHARS = 256;
    localparam int FONT_DEPTH = 3072;
    localparam int FONT_AW    = 12;

    typedef enum logic {IDLE, ROWS} state_t;

    // char*12 + row, built from shifts so it maps to two adders
    function automatic logic [FONT_AW-1:0] glyph_addr(input logic [7:0] c, input logic [3:0] row);
        logic [FONT_AW-1:0] cw;
        cw = {4'b0000, c};
        return (cw << 3) + (cw << 2) + {8'h00, row};
    endfunction

endpackage

// File: rtl/font_glyph_writer_if.sv
// Byte-stream handshake carrying glyph frames into the writer.
interface font_glyph_writer_if;
    logic [7:0] in_data;
    logic       in_first;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, in_first, in_valid, input in_ready);
    modport slave  (input in_data, in_first, in_valid, output in_ready);
endinterface

// File: rtl/font_glyph_writer_ram.sv
// 3072x8 font RAM: one synchronous write port, one registered read-first read port.
module font_ram
    import font_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [FONT_AW-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [FONT_AW-1:0] raddr,
    output logic [7:0]         rdata
);

    logic [7:0] mem [FONT_DEPTH];

    // Non-blocking read and write in one process give old data on a same-address collision
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/font_glyph_writer.sv
// Glyph frame writer: FSM loads 12-row glyphs into the font RAM, gated by wr_window.
module font_glyph_writer
    import font_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    font_glyph_writer_if.slave        stream,
    input  logic                      wr_window,
    input  logic [7:0]                char,
    input  logic [3:0]                yofs,
    output logic [7:0]                bits,
    output logic                      busy,
    output logic                      glyph_done,
    output logic                      err
);

    localparam logic [3:0] LAST_ROW = 4'(FONT_ROWS - 1);
    localparam logic [3:0] NUM_ROWS = 4'(FONT_ROWS);

    state_t             state, state_nx;
    logic [7:0]         cur_char, cur_char_nx;
    logic [3:0]         row_cnt, row_cnt_nx;
    logic               done_nx, err_nx;
    logic               accept, wr_req, ram_we;
    logic               rd_ok, rd_ok_nx;
    logic [FONT_AW-1:0] waddr, raddr;
    logic [7:0]         ram_q;

    assign stream.in_ready = (state == IDLE) || wr_window;
    assign accept          = stream.in_valid && stream.in_ready;
    assign busy            = (state == ROWS);

    always_comb begin
        state_nx    = state;
        cur_char_nx = cur_char;
        row_cnt_nx  = row_cnt;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        wr_req      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (stream.in_first) begin
                        cur_char_nx = stream.in_data;
                        row_cnt_nx  = 4'd0;
                        state_nx    = ROWS;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ROWS: begin
                if (accept) begin
                    if (stream.in_first) begin
                        // Abort: restart on the new glyph, rows already written stay
                        err_nx      = 1'b1;
                        cur_char_nx = stream.in_data;
                        row_cnt_nx  = 4'd0;
                    end else begin
                        wr_req = 1'b1;
                        if (row_cnt == LAST_ROW) begin
                            done_nx    = 1'b1;
                            row_cnt_nx = 4'd0;
                            state_nx   = IDLE;
                        end else begin
                            row_cnt_nx = row_cnt + 4'd1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_char   <= 8'h00;
            row_cnt    <= 4'd0;
            glyph_done <= 1'b0;
            err        <= 1'b0;
            rd_ok      <= 1'b0;
        end else begin
            state      <= state_nx;
            cur_char   <= cur_char_nx;
            row_cnt    <= row_cnt_nx;
            glyph_done <= done_nx;
            err        <= err_nx;
            rd_ok      <= rd_ok_nx;
        end
    end

    // Out-of-range rows read a harmless in-range address and are masked to zero
    assign rd_ok_nx = (yofs < NUM_ROWS);
    assign raddr    = glyph_addr(char, rd_ok_nx ? yofs : 4'd0);
    assign waddr    = glyph_addr(cur_char, row_cnt);
    assign ram_we   = wr_req && !reset;

    font_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (stream.in_data),
        .raddr (raddr),
        .rdata (ram_q)
    );

    assign bits = rd_ok ? ram_q : 8'h00;

endmodule

// File: tb/tb_font_glyph_writer.sv
// Directed bench for font_glyph_writer: frames, stalls, aborts, boundaries, reset.
module tb_font_glyph_writer;
    import font_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_window;
    logic [7:0] char;
    logic [3:0] yofs;
    logic [7:0] bits;
    logic       busy, glyph_done, err;
    int         vectors = 0;
    int         miscompares = 0;

    font_glyph_writer_if sif ();

    font_glyph_writer dut (
        .clk        (clk),
        .reset      (reset),
        .stream     (sif),
        .wr_window  (wr_window),
        .char       (char),
        .yofs       (yofs),
        .bits       (bits),
        .busy       (busy),
        .glyph_done (glyph_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a byte from a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] d, input logic f);
        int n;
        n = 0;
        sif.in_data  = d;
        sif.in_first = f;
        sif.in_valid = 1'b1;
        #1;
        while (!sif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 8'(sif.in_ready), 8'h01);
        @(negedge clk);
    endtask

    task automatic idle();
        sif.in_valid = 1'b0;
        sif.in_first = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] c, input logic [3:0] y, input logic [7:0] exp);
        char = c;
        yofs = y;
        @(negedge clk);
        check(tag, bits, exp);
    endtask

    task automatic fill(input logic [7:0] c, input logic [7:0] v);
        send(c, 1'b1);
        for (int i = 0; i < 12; i++) send(v, 1'b0);
        check("fill_done", 8'(glyph_done), 8'h01);
        idle();
        @(negedge clk);
    endtask

    logic [7:0] ra [12];

    initial begin
        ra = '{8'h00, 8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h00, 8'h00, 8'h00};
        reset = 1'b1; wr_window = 1'b1; char = 8'h00; yofs = 4'd0;
        sif.in_data = 8'h00; sif.in_first = 1'b0; sif.in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", 8'(sif.in_ready), 8'h01);
        check("rst_busy",  8'(busy),         8'h00);
        check("rst_done",  8'(glyph_done),   8'h00);
        check("rst_err",   8'(err),          8'h00);
        check("rst_bits",  bits,             8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Full frame, continuous: done pulse in the cycle after the 13th acceptance
        send(8'h41, 1'b1);
        check("a_busy", 8'(busy), 8'h01);
        for (int i = 0; i < 12; i++) begin
            send(ra[i], 1'b0);
            check($sformatf("a_done_r%0d", i), 8'(glyph_done), 8'(i == 11));
        end
        idle();
        check("a_busy_end", 8'(busy), 8'h00);
        @(negedge clk);
        check("a_done_1cyc", 8'(glyph_done), 8'h00);
        for (int i = 0; i < 12; i++) rd($sformatf("a_rd%0d", i), 8'h41, 4'(i), ra[i]);
        yofs = 4'd1;
        #1 check("a_latency_hold", bits, ra[11]);
        @(negedge clk);
        check("a_latency_new", bits, ra[1]);

        // Window stall after row 4
        send(8'h20, 1'b1);
        for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
        sif.in_data = 8'h65; sif.in_first = 1'b0; sif.in_valid = 1'b1; wr_window = 1'b0;
        #1 check("s_ready_low", 8'(sif.in_ready), 8'h00);
        repeat (20) @(negedge clk);
        check("s_ready_still", 8'(sif.in_ready), 8'h00);
        check("s_busy", 8'(busy), 8'h01);
        check("s_no_done", 8'(glyph_done), 8'h00);
        wr_window = 1'b1;
        for (int i = 5; i < 12; i++) begin
            send(8'(8'h60 + i), 1'b0);
            check($sformatf("s_done_r%0d", i), 8'(glyph_done), 8'(i == 11));
        end
        idle();
        @(negedge clk);
        check("s_done_once", 8'(glyph_done), 8'h00);
        for (int i = 0; i < 12; i++) rd($sformatf("s_rd%0d", i), 8'h20, 4'(i), 8'(8'h60 + i));

        // Abort 0x10 after 5 rows, restart as 0x11
        fill(8'h10, 8'hEE);
        send(8'h10, 1'b1);
        for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b0);
        check("b_no_err", 8'(err), 8'h00);
        send(8'h11, 1'b1);
        check("b_err", 8'(err), 8'h01);
        check("b_busy", 8'(busy), 8'h01);
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h80 + i), 1'b0);
            if (i == 0) check("b_err_1cyc", 8'(err), 8'h00);
        end
        check("b_done", 8'(glyph_done), 8'h01);
        idle();
        @(negedge clk);
        for (int i = 0; i < 12; i++)
            rd($sformatf("b_old%0d", i), 8'h10, 4'(i), (i < 5) ? 8'(i + 1) : 8'hEE);
        for (int i = 0; i < 12; i++) rd($sformatf("b_new%0d", i), 8'h11, 4'(i), 8'(8'h80 + i));

        // Stray row byte while idle
        send(8'h55, 1'b0);
        check("c_err", 8'(err), 8'h01);
        check("c_busy", 8'(busy), 8'h00);
        idle();
        @(negedge clk);
        check("c_err_1cyc", 8'(err), 8'h00);
        rd("c_no_write", 8'h11, 4'd0, 8'h80);

        // Top of RAM, out-of-range rows, same-address read/write collision
        send(8'hFF, 1'b1);
        for (int i = 0; i < 11; i++) send(8'(i), 1'b0);
        send(8'hA5, 1'b0);
        idle();
        @(negedge clk);
        rd("d_top", 8'hFF, 4'd11, 8'hA5);
        for (int y = 12; y < 16; y++) rd($sformatf("d_oor%0d", y), 8'hFF, 4'(y), 8'h00);
        send(8'hFF, 1'b1);
        for (int i = 0; i < 11; i++) send(8'(i), 1'b0);
        char = 8'hFF; yofs = 4'd11;
        sif.in_data = 8'h5A; sif.in_first = 1'b0; sif.in_valid = 1'b1;
        @(negedge clk);
        check("d_rw_old", bits, 8'hA5);
        check("d_rw_done", 8'(glyph_done), 8'h01);
        idle();
        @(negedge clk);
        check("d_rw_new", bits, 8'h5A);

        // Reset after row 6 written
        fill(8'h30, 8'hCC);
        send(8'h30, 1'b1);
        for (int i = 0; i < 7; i++) send(8'(8'h30 + i), 1'b0);
        check("e_busy_pre", 8'(busy), 8'h01);
        idle();
        reset = 1'b1;
        @(negedge clk);
        check("e_ready", 8'(sif.in_ready), 8'h01);
        check("e_busy",  8'(busy),         8'h00);
        check("e_done",  8'(glyph_done),   8'h00);
        check("e_err",   8'(err),          8'h00);
        reset = 1'b0;
        for (int i = 0; i < 12; i++)
            rd($sformatf("e_rd%0d", i), 8'h30, 4'(i), (i < 7) ? 8'(8'h30 + i) : 8'hCC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
